// File: rtl/piles_pkg.sv
// ============================================================================
// Module  : piles_pkg
// Brief   : Shared definitions for the stack-management and gravity blocks.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package piles_pkg;

  localparam int ROW_COUNT_DEFAULT = 6;

  localparam logic [1:0] COL_GAUCHE = 2'd0;
  localparam logic [1:0] COL_CENTRE = 2'd1;
  localparam logic [1:0] COL_DROITE = 2'd2;

  typedef enum logic {
    PLAY = 1'b0,
    LOST = 1'b1
  } etat_t;

endpackage

`default_nettype wire

// File: rtl/diviseur_pulse.sv
// ============================================================================
// Module  : diviseur_pulse
// Brief   : One-cycle tick every TICKS_PAR_LIGNE enabled clock cycles.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module diviseur_pulse #(
  parameter int TICKS_PAR_LIGNE = 25000000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic pulse
);

  localparam int            CW   = (TICKS_PAR_LIGNE > 1) ? $clog2(TICKS_PAR_LIGNE) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS_PAR_LIGNE - 1);

  logic [CW-1:0] r_cnt;
  logic          r_pulse;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else if (clear || !enable) begin
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else if (r_cnt == LAST) begin
      r_cnt   <= '0;
      r_pulse <= 1'b1;
    end else begin
      r_cnt   <= r_cnt + CW'(1);
      r_pulse <= 1'b0;
    end
  end

  assign pulse = r_pulse;

endmodule

`default_nettype wire

// File: rtl/gestion_piles.sv
// ============================================================================
// Module  : gestion_piles
// Brief   : Three-stack height tracking, row clearing, lost detection and the
//           fall tick. Optional score counter under GESTION_PILES_SCORE_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module gestion_piles
  import piles_pkg::*;
#(
  parameter int ROW_COUNT       = ROW_COUNT_DEFAULT,
  parameter int TICKS_PAR_LIGNE = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       PlusGauche,
  input  logic       PlusCentre,
  input  logic       PlusDroite,
  input  logic       Aligne,
  input  logic [1:0] col,
  input  logic       restart,
  output logic [2:0] hauteurGauche,
  output logic [2:0] hauteurCentre,
  output logic [2:0] hauteurDroite,
  output logic       pulse,
`ifdef GESTION_PILES_SCORE_EN
  output logic [7:0] Score,
`endif
  output logic       EtatPerdu
);

  localparam logic [2:0] H_MAX = 3'(ROW_COUNT - 1);

  etat_t      r_state, w_state_next;
  logic [2:0] r_hg, r_hc, r_hd;
  logic [2:0] w_hg_next, w_hc_next, w_hd_next;
  logic       r_perdu;
  logic       w_align_ok;
  logic       w_full_hit;

  always_comb begin
    w_state_next = r_state;
    w_hg_next    = r_hg;
    w_hc_next    = r_hc;
    w_hd_next    = r_hd;
    w_align_ok   = 1'b0;
    w_full_hit   = 1'b0;

    if (restart) begin
      w_state_next = PLAY;
      w_hg_next    = '0;
      w_hc_next    = '0;
      w_hd_next    = '0;
    end else if (r_state == PLAY) begin
      if (Aligne) begin
        // Landing stack keeps its height; an Aligne cycle never applies Plus pulses.
        case (col)
          COL_GAUCHE: w_align_ok = (r_hc != '0) && (r_hd != '0);
          COL_CENTRE: w_align_ok = (r_hg != '0) && (r_hd != '0);
          COL_DROITE: w_align_ok = (r_hg != '0) && (r_hc != '0);
          default:    w_align_ok = 1'b0;
        endcase
        if (w_align_ok) begin
          if (col != COL_GAUCHE) w_hg_next = r_hg - 3'd1;
          if (col != COL_CENTRE) w_hc_next = r_hc - 3'd1;
          if (col != COL_DROITE) w_hd_next = r_hd - 3'd1;
        end
      end else begin
        if (PlusGauche) begin
          if (r_hg == H_MAX) w_full_hit = 1'b1;
          else               w_hg_next  = r_hg + 3'd1;
        end
        if (PlusCentre) begin
          if (r_hc == H_MAX) w_full_hit = 1'b1;
          else               w_hc_next  = r_hc + 3'd1;
        end
        if (PlusDroite) begin
          if (r_hd == H_MAX) w_full_hit = 1'b1;
          else               w_hd_next  = r_hd + 3'd1;
        end
      end

      if (w_full_hit || (w_hg_next == H_MAX) || (w_hc_next == H_MAX) ||
          (w_hd_next == H_MAX)) begin
        w_state_next = LOST;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= PLAY;
      r_hg    <= '0;
      r_hc    <= '0;
      r_hd    <= '0;
      r_perdu <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_hg    <= w_hg_next;
      r_hc    <= w_hc_next;
      r_hd    <= w_hd_next;
      r_perdu <= (w_state_next == LOST);
    end
  end

`ifdef GESTION_PILES_SCORE_EN
  logic [7:0] r_score;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_score <= '0;
    end else if (restart) begin
      r_score <= '0;
    end else if (w_align_ok && (r_score != 8'hFF)) begin
      r_score <= r_score + 8'd1;
    end
  end

  assign Score = r_score;
`endif

  // The tick must already be silent in the first LOST cycle, so gate on next state.
  diviseur_pulse #(
    .TICKS_PAR_LIGNE (TICKS_PAR_LIGNE)
  ) u_diviseur (
    .clk    (clk),
    .reset  (reset),
    .enable (w_state_next == PLAY),
    .clear  (restart),
    .pulse  (pulse)
  );

  assign hauteurGauche = r_hg;
  assign hauteurCentre = r_hc;
  assign hauteurDroite = r_hd;
  assign EtatPerdu     = r_perdu;

endmodule

`default_nettype wire

// File: tb/tb_gestion_piles.sv
// ============================================================================
// Module  : tb_gestion_piles
// Brief   : Directed, table-driven self-checking bench for gestion_piles.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gestion_piles;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       PlusGauche = 1'b0, PlusCentre = 1'b0, PlusDroite = 1'b0;
  logic       Aligne = 1'b0;
  logic [1:0] col = 2'd0;
  logic       restart = 1'b0;
  logic [2:0] hauteurGauche, hauteurCentre, hauteurDroite;
  logic       pulse, EtatPerdu;
`ifdef GESTION_PILES_SCORE_EN
  logic [7:0] Score;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gestion_piles #(
    .ROW_COUNT       (6),
    .TICKS_PAR_LIGNE (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .PlusGauche    (PlusGauche),
    .PlusCentre    (PlusCentre),
    .PlusDroite    (PlusDroite),
    .Aligne        (Aligne),
    .col           (col),
    .restart       (restart),
    .hauteurGauche (hauteurGauche),
    .hauteurCentre (hauteurCentre),
    .hauteurDroite (hauteurDroite),
    .pulse         (pulse),
`ifdef GESTION_PILES_SCORE_EN
    .Score         (Score),
`endif
    .EtatPerdu     (EtatPerdu)
  );

  typedef struct {
    logic       pg, pc, pd, al;
    logic [1:0] cl;
    logic       rs;
    logic [2:0] eg, ec, ed;
    logic       el;
    logic [7:0] es;
  } vec_t;

  vec_t vecs[24];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Inputs held for one full clock cycle; outputs sampled at the following negedge.
  task automatic step(input logic pg, pc, pd, al, input logic [1:0] cl, input logic rs);
    @(negedge clk);
    PlusGauche = pg; PlusCentre = pc; PlusDroite = pd;
    Aligne = al; col = cl; restart = rs;
    @(negedge clk);
    PlusGauche = 1'b0; PlusCentre = 1'b0; PlusDroite = 1'b0;
    Aligne = 1'b0; col = 2'd0; restart = 1'b0;
  endtask

  task automatic chk_heights(input string tag, input int g, input int c, input int d);
    chk({tag, " G"}, int'(hauteurGauche), g);
    chk({tag, " C"}, int'(hauteurCentre), c);
    chk({tag, " D"}, int'(hauteurDroite), d);
  endtask

  initial begin
    //            pg    pc    pd    al    col   rs    G C D lost score
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 0, 0, 0, 1'b0, 0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 0, 1, 0, 1'b0, 0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 0, 2, 0, 1'b0, 0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 0, 3, 0, 1'b0, 0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 0, 0, 0, 1'b0, 0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1, 1, 0, 1'b0, 0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2, 1, 0, 1'b0, 0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1, 0, 0, 1'b0, 1};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1, 0, 0, 1'b0, 1};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1, 1, 0, 1'b0, 1};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1, 1, 1, 1'b0, 1};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1, 0, 0, 1'b0, 2};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1, 1, 0, 1'b0, 2};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1, 1, 1, 1'b0, 2};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 1, 1, 1, 1'b0, 2};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 0, 1, 0, 1'b0, 3};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 0, 1, 1, 1'b0, 3};
    vecs[17] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 0, 1, 2, 1'b0, 3};
    vecs[18] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 0, 1, 3, 1'b0, 3};
    vecs[19] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 0, 1, 4, 1'b0, 3};
    vecs[20] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 0, 1, 5, 1'b1, 3};
    vecs[21] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 0, 1, 5, 1'b1, 3};
    vecs[22] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 0, 1, 5, 1'b1, 3};
    vecs[23] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 0, 0, 0, 1'b0, 0};

    // Reset state while reset is held low.
    #23;
    chk_heights("reset", 0, 0, 0);
    chk("reset pulse", int'(pulse), 0);
    chk("reset lost", int'(EtatPerdu), 0);
`ifdef GESTION_PILES_SCORE_EN
    chk("reset score", int'(Score), 0);
`endif

    // Free-running ticks after release: pulse at edges 4, 8, 12.
    @(negedge clk);
    reset = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      @(posedge clk); #1;
      chk($sformatf("idle pulse edge%0d", k), int'(pulse), (k % 4 == 0) ? 1 : 0);
    end
    chk_heights("idle", 0, 0, 0);
    chk("idle lost", int'(EtatPerdu), 0);

    for (int i = 0; i < 24; i++) begin
      step(vecs[i].pg, vecs[i].pc, vecs[i].pd, vecs[i].al, vecs[i].cl, vecs[i].rs);
      chk_heights($sformatf("vec%0d", i), vecs[i].eg, vecs[i].ec, vecs[i].ed);
      chk($sformatf("vec%0d lost", i), int'(EtatPerdu), int'(vecs[i].el));
`ifdef GESTION_PILES_SCORE_EN
      chk($sformatf("vec%0d score", i), int'(Score), int'(vecs[i].es));
`endif
    end

    // LOST: tick silent, heights frozen, restart re-arms the tick 4 edges later.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
    chk("lost entry", int'(EtatPerdu), 1);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      chk($sformatf("lost pulse%0d", k), int'(pulse), 0);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    chk_heights("lost frozen", 0, 0, 5);
    step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
    chk_heights("restart", 0, 0, 0);
    chk("restart lost", int'(EtatPerdu), 0);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("restart pulse edge%0d", k), int'(pulse), (k == 4) ? 1 : 0);
    end

    // Asynchronous reset mid-count with G=3.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    chk("pre-reset G", int'(hauteurGauche), 3);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    chk_heights("async reset", 0, 0, 0);
    chk("async reset pulse", int'(pulse), 0);
    chk("async reset lost", int'(EtatPerdu), 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("post-reset pulse edge%0d", k), int'(pulse), (k == 4) ? 1 : 0);
    end
    chk_heights("post-reset", 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
